// File: rtl/tx_encoder.sv
// tx_encoder: byte-to-10-bit transmit line encoder.
// A one-byte holding stage (S1) sits behind a valid/ready handshake.
// Each serializer load strobe moves S1, or the idle byte when S1 is empty,
// into the registered code word, and updates a saturating running disparity.
// Optional build macro ENC_STATS_EN adds data/idle load counters with a clear input.
module tx_encoder #(
    parameter logic [7:0] IDLE_BYTE = 8'hBC,
    parameter int         RD_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 din,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic                       tx_load,
    output logic [9:0]                 dout,
    output logic                       dout_idle,
`ifdef ENC_STATS_EN
    input  logic                       stats_clr,
    output logic [15:0]                data_cnt,
    output logic [15:0]                idle_cnt,
`endif
    output logic signed [RD_WIDTH-1:0] rd_acc
);

    localparam logic signed [RD_WIDTH-1:0] RD_MAX = {1'b0, {(RD_WIDTH-1){1'b1}}};
    localparam logic signed [RD_WIDTH-1:0] RD_MIN = {1'b1, {(RD_WIDTH-1){1'b0}}};

    function automatic logic [3:0] enc_3b4b(input logic [2:0] v);
        case (v)
            3'd0: enc_3b4b = 4'b0100;
            3'd1: enc_3b4b = 4'b1001;
            3'd2: enc_3b4b = 4'b0101;
            3'd3: enc_3b4b = 4'b0011;
            3'd4: enc_3b4b = 4'b0010;
            3'd5: enc_3b4b = 4'b1010;
            3'd6: enc_3b4b = 4'b0110;
            3'd7: enc_3b4b = 4'b0001;
        endcase
    endfunction

    function automatic logic [5:0] enc_5b6b(input logic [4:0] v);
        case (v)
            5'h00: enc_5b6b = 6'b011000;
            5'h01: enc_5b6b = 6'b011101;
            5'h02: enc_5b6b = 6'b010010;
            5'h03: enc_5b6b = 6'b110001;
            5'h04: enc_5b6b = 6'b110101;
            5'h05: enc_5b6b = 6'b101001;
            5'h06: enc_5b6b = 6'b011001;
            5'h07: enc_5b6b = 6'b111000;
            5'h08: enc_5b6b = 6'b111001;
            5'h09: enc_5b6b = 6'b100101;
            5'h0A: enc_5b6b = 6'b010101;
            5'h0B: enc_5b6b = 6'b110100;
            5'h0C: enc_5b6b = 6'b001101;
            5'h0D: enc_5b6b = 6'b101100;
            5'h0E: enc_5b6b = 6'b011100;
            5'h0F: enc_5b6b = 6'b010111;
            5'h10: enc_5b6b = 6'b011011;
            5'h11: enc_5b6b = 6'b100011;
            5'h12: enc_5b6b = 6'b010011;
            5'h13: enc_5b6b = 6'b110010;
            5'h14: enc_5b6b = 6'b001011;
            5'h15: enc_5b6b = 6'b101010;
            5'h16: enc_5b6b = 6'b011010;
            5'h17: enc_5b6b = 6'b111010;
            5'h18: enc_5b6b = 6'b110011;
            5'h19: enc_5b6b = 6'b100110;
            5'h1A: enc_5b6b = 6'b010110;
            5'h1B: enc_5b6b = 6'b110110;
            5'h1C: enc_5b6b = 6'b001110;
            5'h1D: enc_5b6b = 6'b101110;
            5'h1E: enc_5b6b = 6'b011110;
            5'h1F: enc_5b6b = 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] popcount10(input logic [9:0] c);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, c[i]};
        end
        return n;
    endfunction

    // Two guard bits so acc + d (|d| <= 10) cannot wrap even at RD_WIDTH = 4.
    function automatic logic signed [RD_WIDTH-1:0] sat_add(
        input logic signed [RD_WIDTH-1:0] acc,
        input logic signed [5:0]          d
    );
        logic signed [RD_WIDTH+1:0] sum;
        sum = (RD_WIDTH+2)'(acc) + (RD_WIDTH+2)'(d);
        if (sum > (RD_WIDTH+2)'(RD_MAX)) begin
            return RD_MAX;
        end else if (sum < (RD_WIDTH+2)'(RD_MIN)) begin
            return RD_MIN;
        end else begin
            return sum[RD_WIDTH-1:0];
        end
    endfunction

    logic [7:0]                 r_s1;
    logic                       r_s1_full;
    logic [9:0]                 r_dout;
    logic                       r_dout_idle;
    logic signed [RD_WIDTH-1:0] r_rd_acc;

    logic                       w_accept;
    logic [7:0]                 w_src_byte;
    logic [9:0]                 w_code;
    logic signed [5:0]          w_disp;

    // A load frees S1 in the same cycle, so a full S1 can still accept then.
    assign din_ready  = !r_s1_full || tx_load;
    assign w_accept   = din_valid && din_ready;
    assign w_src_byte = r_s1_full ? r_s1 : IDLE_BYTE;
    assign w_code     = {enc_3b4b(w_src_byte[7:5]), enc_5b6b(w_src_byte[4:0])};
    assign w_disp     = $signed({1'b0, popcount10(w_code), 1'b0}) - 6'sd10;

    // S1 data byte; validity lives in r_s1_full so the data needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1 <= din;
        end
    end

    // S1 occupancy and the S2 code word / idle flag / disparity, all moving on tx_load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_full   <= 1'b0;
            r_dout      <= 10'h000;
            r_dout_idle <= 1'b0;
            r_rd_acc    <= '0;
        end else begin
            if (w_accept) begin
                r_s1_full <= 1'b1;
            end else if (tx_load) begin
                r_s1_full <= 1'b0;
            end
            if (tx_load) begin
                r_dout      <= w_code;
                r_dout_idle <= !r_s1_full;
                r_rd_acc    <= sat_add(r_rd_acc, w_disp);
            end
        end
    end

    assign dout      = r_dout;
    assign dout_idle = r_dout_idle;
    assign rd_acc    = r_rd_acc;

`ifdef ENC_STATS_EN
    logic [15:0] r_data_cnt;
    logic [15:0] r_idle_cnt;

    // Load counters, wrapping at 16 bits; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_cnt <= 16'd0;
            r_idle_cnt <= 16'd0;
        end else if (stats_clr) begin
            r_data_cnt <= 16'd0;
            r_idle_cnt <= 16'd0;
        end else if (tx_load) begin
            if (r_s1_full) begin
                r_data_cnt <= r_data_cnt + 16'd1;
            end else begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
        end
    end

    assign data_cnt = r_data_cnt;
    assign idle_cnt = r_idle_cnt;
`endif

endmodule

// File: tb/tb_tx_encoder.sv
// Bench for tx_encoder: a queue-based transaction model compared every cycle,
// plus literal code/disparity expectations and a full 256-byte decode sweep.
`timescale 1ns/1ps
module tb_tx_encoder;

    localparam logic [7:0] IDLE = 8'hBC;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic [7:0]        din       = 8'h00;
    logic              din_valid = 1'b0;
    logic              tx_load   = 1'b0;
    logic              din_ready, din_ready4;
    logic              dout_idle, dout_idle4;
    logic [9:0]        dout, dout4;
    logic signed [7:0] rd_acc;
    logic signed [3:0] rd_acc4;
`ifdef ENC_STATS_EN
    logic              stats_clr = 1'b0;
    logic [15:0]       data_cnt, idle_cnt, data_cnt4, idle_cnt4;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tx_encoder #(.IDLE_BYTE(8'hBC), .RD_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx_load(tx_load), .dout(dout), .dout_idle(dout_idle),
`ifdef ENC_STATS_EN
        .stats_clr(stats_clr), .data_cnt(data_cnt), .idle_cnt(idle_cnt),
`endif
        .rd_acc(rd_acc)
    );

    tx_encoder #(.IDLE_BYTE(8'hBC), .RD_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready4), .tx_load(tx_load), .dout(dout4), .dout_idle(dout_idle4),
`ifdef ENC_STATS_EN
        .stats_clr(stats_clr), .data_cnt(data_cnt4), .idle_cnt(idle_cnt4),
`endif
        .rd_acc(rd_acc4)
    );

    // Code tables as written in the specification.
    logic [3:0] T4 [8]  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [5:0] T6 [32] = '{6'b011000, 6'b011101, 6'b010010, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                            6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                            6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};

    function automatic logic [9:0] enc(input logic [7:0] b);
        return {T4[b[7:5]], T6[b[4:0]]};
    endfunction

    // Receive-side decoder: inverse table search.
    function automatic int dec(input logic [9:0] c);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 32; j++) begin
                if (T4[i] == c[9:6] && T6[j] == c[5:0]) return i * 32 + j;
            end
        end
        return -1;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: queue of accepted bytes, popped by loads.
    logic [7:0] q[$];
    logic [9:0] m_dout = 10'h000;
    bit         m_idle = 1'b0;
    int         m_rd = 0, m_rd4 = 0;
    bit         m_loaded = 1'b0;
    int         m_data_cnt = 0, m_idle_cnt = 0;
    bit         m_take;
    logic [7:0] m_byte;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_dout = 10'h000; m_idle = 1'b0; m_rd = 0; m_rd4 = 0;
            m_loaded = 1'b0; m_data_cnt = 0; m_idle_cnt = 0;
        end else begin
            m_take   = din_valid && (q.size() == 0 || tx_load);
            m_loaded = tx_load;
            if (tx_load) begin
                if (q.size() > 0) begin
                    m_byte = q.pop_front(); m_idle = 1'b0;
                end else begin
                    m_byte = IDLE; m_idle = 1'b1;
                end
                m_dout = enc(m_byte);
                m_rd   = clamp(m_rd  + 2 * $countones(m_dout) - 10, -128, 127);
                m_rd4  = clamp(m_rd4 + 2 * $countones(m_dout) - 10, -8, 7);
            end
`ifdef ENC_STATS_EN
            if (stats_clr) begin
                m_data_cnt = 0; m_idle_cnt = 0;
            end else if (tx_load) begin
                if (m_idle) m_idle_cnt = (m_idle_cnt + 1) & 32'hFFFF;
                else        m_data_cnt = (m_data_cnt + 1) & 32'hFFFF;
            end
`endif
            if (m_take) q.push_back(din);
        end
    end

    // Per-cycle comparison on the falling edge; also captures data codes for decoding.
    bit         collect = 1'b0;
    logic [9:0] got[$];

    always @(negedge clk) begin
        if (reset) begin
            chk("din_ready",  din_ready,  (q.size() == 0 || tx_load) ? 1 : 0);
            chk("din_ready4", din_ready4, (q.size() == 0 || tx_load) ? 1 : 0);
            chk("dout",       dout,       m_dout);
            chk("dout_idle",  dout_idle,  m_idle);
            chk("dout4",      dout4,      m_dout);
            chk("rd_acc",     rd_acc,     m_rd);
            chk("rd_acc4",    rd_acc4,    m_rd4);
`ifdef ENC_STATS_EN
            chk("data_cnt",   data_cnt,   m_data_cnt);
            chk("idle_cnt",   idle_cnt,   m_idle_cnt);
`endif
            if (collect && m_loaded && !dout_idle) got.push_back(dout);
        end
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit l);
        din_valid = v; din = d; tx_load = l;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0; #2; reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_idle", dout_idle, 0);
        chk("rst_rd", rd_acc, 0);
        reset = 1'b1;
        #1;
        chk("rst_ready", din_ready, 1);

        // Idle insertion
        drive(0, 8'h00, 1);
        chk("idle_code", dout, 10'h28E);
        chk("idle_flag", dout_idle, 1);
        chk("idle_rd", rd_acc, 0);

        // 0x00 then 0xFF
        drive(1, 8'h00, 0);
        drive(0, 8'h00, 1);
        chk("enc00", dout, 10'h118);
        chk("enc00_idle", dout_idle, 0);
        chk("enc00_rd", rd_acc, -4);
        drive(1, 8'hFF, 0);
        drive(0, 8'h00, 1);
        chk("encFF", dout, 10'h06B);
        chk("encFF_rd", rd_acc, -4);

        // Backpressure then streaming
        drive(1, 8'h11, 0);
        chk("bp_ready", din_ready, 0);
        drive(1, 8'h22, 0);
        drive(1, 8'h22, 0);
        drive(1, 8'h22, 1);
        chk("stream11", dout, 10'h123);
        drive(1, 8'h33, 1);
        chk("stream22", dout, 10'h252);
        drive(1, 8'h44, 1);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 1);
        chk("stream_end_idle", dout_idle, 1);

        // Accept and load with S1 empty: no bypass
        drive(1, 8'h5A, 1);
        chk("nobypass_idle", dout_idle, 1);
        drive(0, 8'h00, 1);
        chk("enc5A", dout, 10'h156);
        chk("enc5A_idle", dout_idle, 0);

        // Saturation with RD_WIDTH = 4
        pulse_reset();
        drive(1, 8'h00, 0);
        drive(1, 8'h00, 1);
        chk("sat4_1", rd_acc4, -4);
        drive(1, 8'h00, 1);
        chk("sat4_2", rd_acc4, -8);
        drive(0, 8'h00, 1);
        chk("sat4_3", rd_acc4, -8);
        chk("sat8_3", rd_acc, -12);

        // Reset with a byte pending in S1
        drive(1, 8'h77, 0);
        reset = 1'b0;
        #1;
        chk("midrst_dout", dout, 0);
        chk("midrst_rd", rd_acc, 0);
        chk("midrst_rd4", rd_acc4, 0);
        reset = 1'b1;
        drive(0, 8'h00, 1);
        chk("midrst_code", dout, 10'h28E);
        chk("midrst_flag", dout_idle, 1);

        // Full sweep through the decoder
        pulse_reset();
        got.delete();
        collect = 1'b1;
        for (int b = 0; b < 256; b++) drive(1, 8'(b), 1);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 0);
        collect = 1'b0;
        chk("sweep_count", got.size(), 256);
        for (int i = 0; i < got.size(); i++) chk("sweep_decode", dec(got[i]), i);
`ifdef ENC_STATS_EN
        chk("stats_data256", data_cnt, 256);
        chk("stats_idle1", idle_cnt, 1);
        stats_clr = 1'b1;
        drive(0, 8'h00, 1);
        stats_clr = 1'b0;
        chk("stats_clr_data", data_cnt, 0);
        chk("stats_clr_idle", idle_cnt, 0);
        drive(0, 8'h00, 1);
        chk("stats_after_clr", idle_cnt, 1);
`endif
        drive(0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
